// File: rtl/traffic_pkg.sv
// Shared lamp codes and state encodings for the highway/country junction controller.
package traffic_pkg;

    localparam logic [1:0] RED    = 2'd0;
    localparam logic [1:0] YELLOW = 2'd1;
    localparam logic [1:0] GREEN  = 2'd2;
    localparam logic [1:0] OFF    = 2'd3;

    typedef enum logic [2:0] {
        S_HG   = 3'd0,
        S_HY   = 3'd1,
        S_AR_C = 3'd2,
        S_CG   = 3'd3,
        S_CY   = 3'd4,
        S_AR_H = 3'd5,
        S_FL   = 3'd6
    } state_t;

endpackage

// File: rtl/traffic_dwell_timer.sv
// Saturating dwell counter: counts cycles spent in the current state, cleared on restart.
module traffic_dwell_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             restart,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clear || restart) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_ctrl_param.sv
// Highway/country junction controller: Moore FSM with min/max greens, all-red clearance and flash mode.
module traffic_ctrl_param
    import traffic_pkg::*;
#(
    parameter int Y2R_CYC         = 3,
    parameter int R2G_CYC         = 2,
    parameter int HWY_MIN_GREEN   = 8,
    parameter int CNTRY_MAX_GREEN = 16,
    parameter int FLASH_HALF      = 4,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       x,
    input  logic       flash,
    output logic [1:0] hwy,
    output logic [1:0] cntry,
    output logic [2:0] state_o
);

    localparam logic [CNT_W-1:0] Y2R_LAST   = CNT_W'(Y2R_CYC - 1);
    localparam logic [CNT_W-1:0] R2G_LAST   = CNT_W'(R2G_CYC - 1);
    localparam logic [CNT_W-1:0] HMIN_LAST  = CNT_W'(HWY_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] CMAX_LAST  = CNT_W'(CNTRY_MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_HALF - 1);

    state_t            state;
    state_t            state_next;
    logic              blink;
    logic              blink_next;
    logic              restart;
    logic [CNT_W-1:0]  cnt;

    traffic_dwell_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .clear   (clear),
        .restart (restart),
        .cnt     (cnt)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            state <= S_HG;
            blink <= 1'b0;
        end else begin
            state <= state_next;
            blink <= blink_next;
        end
    end

    always_comb begin
        state_next = state;
        blink_next = 1'b0;
        restart    = 1'b0;
        if (flash && state != S_FL) begin
            state_next = S_FL;
        end else begin
            case (state)
                S_HG:   if (x && cnt >= HMIN_LAST)        state_next = S_HY;
                S_HY:   if (cnt == Y2R_LAST)              state_next = S_AR_C;
                S_AR_C: if (cnt == R2G_LAST)              state_next = S_CG;
                S_CG:   if (!x || cnt == CMAX_LAST)       state_next = S_CY;
                S_CY:   if (cnt == Y2R_LAST)              state_next = S_AR_H;
                S_AR_H: if (cnt == R2G_LAST)              state_next = S_HG;
                S_FL: begin
                    if (!flash) begin
                        state_next = S_AR_H;
                    end else begin
                        // Each half-period restarts the counter and flips the lamp phase.
                        blink_next = blink;
                        if (cnt == FLASH_LAST) begin
                            blink_next = ~blink;
                            restart    = 1'b1;
                        end
                    end
                end
                default: state_next = S_HG;
            endcase
        end
        if (state_next != state) begin
            restart = 1'b1;
        end
    end

    always_comb begin
        hwy     = RED;
        cntry   = RED;
        state_o = state;
        case (state)
            S_HG: hwy   = GREEN;
            S_HY: hwy   = YELLOW;
            S_CG: cntry = GREEN;
            S_CY: cntry = YELLOW;
            S_FL: begin
                hwy   = blink ? OFF : YELLOW;
                cntry = blink ? OFF : RED;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Scoreboard bench for traffic_ctrl_param: directed test-plan sequences then randomized inputs.
module tb_traffic_ctrl_param;

    localparam int Y2R  = 3;
    localparam int R2G  = 2;
    localparam int HMIN = 8;
    localparam int CMAX = 16;
    localparam int FH   = 4;
    localparam int W    = 7;

    logic       clk;
    logic       clear;
    logic       x;
    logic       flash;
    logic [1:0] hwy;
    logic [1:0] cntry;
    logic [2:0] state_o;

    traffic_ctrl_param #(
        .Y2R_CYC(Y2R), .R2G_CYC(R2G), .HWY_MIN_GREEN(HMIN),
        .CNTRY_MAX_GREEN(CMAX), .FLASH_HALF(FH), .CNT_W(8)
    ) dut (
        .clk(clk), .clear(clear), .x(x), .flash(flash),
        .hwy(hwy), .cntry(cntry), .state_o(state_o)
    );

    // clock / reset
    initial begin
        clk   = 1'b0;
        clear = 1'b1;
        x     = 1'b0;
        flash = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int passes = 0;
    logic [W-1:0] exp_q[$];

    // reference model: phase index plus cycles already spent in that phase
    int m_ph   = 0;
    int m_age  = 0;
    bit m_dark = 1'b0;
    int hwy_tab[7]   = '{2, 1, 0, 0, 0, 0, 1};
    int cntry_tab[7] = '{0, 0, 0, 2, 1, 0, 0};

    task automatic enter(input int ph);
        m_ph   = ph;
        m_age  = 0;
        m_dark = 1'b0;
    endtask

    task automatic stay();
        m_age = m_age + 1;
    endtask

    task automatic model_step(input bit c, input bit f, input bit xi);
        int spent;
        spent = m_age + 1;
        if (c) enter(0);
        else if (f && m_ph != 6) enter(6);
        else begin
            case (m_ph)
                0: if (xi && spent >= HMIN) enter(1); else stay();
                1: if (spent == Y2R) enter(2); else stay();
                2: if (spent == R2G) enter(3); else stay();
                3: if (!xi || spent == CMAX) enter(4); else stay();
                4: if (spent == Y2R) enter(5); else stay();
                5: if (spent == R2G) enter(0); else stay();
                default: begin
                    if (!f) enter(5);
                    else if (spent == FH) begin
                        m_dark = ~m_dark;
                        m_age  = 0;
                    end else stay();
                end
            endcase
        end
    endtask

    function automatic logic [W-1:0] expected_vec();
        logic [1:0] h;
        logic [1:0] c;
        h = 2'(hwy_tab[m_ph]);
        c = 2'(cntry_tab[m_ph]);
        if (m_ph == 6 && m_dark) begin
            h = 2'd3;
            c = 2'd3;
        end
        return {3'(m_ph), h, c};
    endfunction

    // driver
    task automatic drive(input bit xi, input bit f, input bit c);
        @(negedge clk);
        x     = xi;
        flash = f;
        clear = c;
        model_step(c, f, xi);
        exp_q.push_back(expected_vec());
    endtask

    task automatic run(input int n, input bit xi, input bit f);
        for (int i = 0; i < n; i++) drive(xi, f, 1'b0);
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got == want) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    endtask

    // monitor / scoreboard
    logic [W-1:0] e;
    logic [1:0]   prev_h;
    logic [1:0]   prev_c;
    bit           prev_ok = 1'b0;
    logic         clr_s;

    initial begin
        forever begin
            @(posedge clk);
            clr_s = clear;
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("state_o", int'(state_o), int'(e[6:4]));
                check("hwy", int'(hwy), int'(e[3:2]));
                check("cntry", int'(cntry), int'(e[1:0]));
                check("conflict", int'(hwy != 2'd0 && cntry != 2'd0 && state_o != 3'd6), 0);
                if (prev_ok) begin
                    check("hwy_yellow_pass",
                          int'(prev_h == 2'd2 && hwy == 2'd0 && !clr_s && state_o != 3'd6), 0);
                    check("cntry_yellow_pass",
                          int'(prev_c == 2'd2 && cntry == 2'd0 && !clr_s && state_o != 3'd6), 0);
                end
                prev_h  = hwy;
                prev_c  = cntry;
                prev_ok = 1'b1;
            end
        end
    end

    // stimulus
    initial begin
        bit rx;
        bit rf;
        // idle highway green with no demand
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        run(30, 1'b0, 1'b0);
        // continuous demand: full cycle with country timeout, then repeat
        drive(1'b0, 1'b0, 1'b1);
        run(70, 1'b1, 1'b0);
        // short glitch before minimum green, then a qualifying request at cnt=10
        drive(1'b0, 1'b0, 1'b1);
        run(3, 1'b0, 1'b0);
        run(2, 1'b1, 1'b0);
        run(5, 1'b0, 1'b0);
        run(3, 1'b1, 1'b0);
        // country demand drops at cnt=5 of country green
        drive(1'b0, 1'b0, 1'b1);
        run(8 + 3 + 2 + 5, 1'b1, 1'b0);
        run(12, 1'b0, 1'b0);
        // flash entered from country green, then released
        drive(1'b0, 1'b0, 1'b1);
        run(8 + 3 + 2 + 4, 1'b1, 1'b0);
        run(20, 1'b1, 1'b1);
        run(6, 1'b0, 1'b0);
        // clear in the middle of all-red clearance
        drive(1'b0, 1'b0, 1'b1);
        run(8 + 3 + 1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        run(12, 1'b1, 1'b0);
        // randomized operation
        rx = 1'b0;
        rf = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) rx = ~rx;
            if ($urandom_range(0, 79) == 0) rf = ~rf;
            drive(rx, rf, $urandom_range(0, 249) == 0);
        end
        repeat (3) @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
